// File: rtl/rs_multi_cdb_pkg.sv
// rs_multi_cdb shared constants.
// Default widths and the tag/slot encodings used by the ALU reservation station.
package rs_multi_cdb_pkg;
  localparam int RS_DEPTH     = 16;
  localparam int RS_ROB_IDX_W = 4;
  localparam int RS_XLEN      = 32;
  localparam int RS_NUM_CDB   = 2;
  localparam int RS_OP_W      = 7;
  localparam int RS_F3_W      = 3;
  // tag = {pending, rob_pos}; pending sits just above rob_pos
  localparam int RS_TAG_PEND  = RS_ROB_IDX_W;
  // no-free-slot marker, wide enough for DEPTH up to 64
  localparam logic [5:0] RS_NPOS = 6'h3F;
endpackage

// File: rtl/rs_multi_cdb_if.sv
// rs_multi_cdb bus: issue port, CDB broadcast ports and ALU dispatch port.
// master = issue/CDB side, slave = reservation station.
interface rs_multi_cdb_if
  import rs_multi_cdb_pkg::*;
#(
  parameter int ROB_IDX_W = RS_ROB_IDX_W,
  parameter int XLEN      = RS_XLEN,
  parameter int NUM_CDB   = RS_NUM_CDB,
  parameter int OP_W      = RS_OP_W,
  parameter int F3_W      = RS_F3_W
);
  logic                      issue;
  logic [OP_W-1:0]           issue_opcode;
  logic [F3_W-1:0]           issue_funct3;
  logic                      issue_funct7;
  logic [XLEN-1:0]           issue_imm;
  logic [XLEN-1:0]           issue_pc;
  logic [ROB_IDX_W-1:0]      issue_rob_pos;
  logic [ROB_IDX_W:0]        issue_rs1_tag;
  logic [ROB_IDX_W:0]        issue_rs2_tag;
  logic [XLEN-1:0]           issue_rs1_val;
  logic [XLEN-1:0]           issue_rs2_val;
  logic                      rs_nxt_full;
  logic                      alu_en;
  logic [OP_W-1:0]           alu_opcode;
  logic [F3_W-1:0]           alu_funct3;
  logic                      alu_funct7;
  logic [XLEN-1:0]           alu_imm;
  logic [XLEN-1:0]           alu_pc;
  logic [XLEN-1:0]           alu_val1;
  logic [XLEN-1:0]           alu_val2;
  logic [ROB_IDX_W-1:0]      alu_rob_pos;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob_pos;
  logic [NUM_CDB*XLEN-1:0]   cdb_val;

  modport master (
    output issue, issue_opcode, issue_funct3, issue_funct7,
    output issue_imm, issue_pc, issue_rob_pos,
    output issue_rs1_tag, issue_rs2_tag,
    output issue_rs1_val, issue_rs2_val,
    output cdb_valid, cdb_rob_pos, cdb_val,
    input  rs_nxt_full, alu_en, alu_opcode, alu_funct3,
    input  alu_funct7, alu_imm, alu_pc, alu_val1,
    input  alu_val2, alu_rob_pos
  );

  modport slave (
    input  issue, issue_opcode, issue_funct3, issue_funct7,
    input  issue_imm, issue_pc, issue_rob_pos,
    input  issue_rs1_tag, issue_rs2_tag,
    input  issue_rs1_val, issue_rs2_val,
    input  cdb_valid, cdb_rob_pos, cdb_val,
    output rs_nxt_full, alu_en, alu_opcode, alu_funct3,
    output alu_funct7, alu_imm, alu_pc, alu_val1,
    output alu_val2, alu_rob_pos
  );
endinterface

// File: rtl/rs_age_pick.sv
// rs_age_pick: DEPTH x DEPTH age matrix, grants the oldest ready entry.
// r_age[j][i] = 1 means entry j is older than entry i.
module rs_age_pick #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] i_busy,
  input  logic [DEPTH-1:0] i_ready,
  input  logic             i_issue,
  input  logic [IDX_W-1:0] i_slot,
  output logic [DEPTH-1:0] o_grant,
  output logic             o_valid
);
  logic [DEPTH-1:0] r_age [DEPTH];

  // new entry becomes younger than every busy entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (i_issue) begin
      r_age[i_slot] <= '0;
      for (int j = 0; j < DEPTH; j++)
        if (j != int'(i_slot)) r_age[j][i_slot] <= i_busy[j];
    end
  end

  // ready entry wins if no other ready entry is older
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (i_ready[j] && r_age[j][i]) o_grant[i] = 1'b0;
    end
  end

  assign o_valid = |o_grant;
endmodule

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: ALU reservation station with NUM_CDB wakeup ports.
// Option RS_CDB_BYPASS_EN: entries woken this cycle may dispatch this cycle.
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int DEPTH     = RS_DEPTH,
  parameter int ROB_IDX_W = RS_ROB_IDX_W,
  parameter int XLEN      = RS_XLEN,
  parameter int NUM_CDB   = RS_NUM_CDB,
  parameter int OP_W      = RS_OP_W,
  parameter int F3_W      = RS_F3_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rollback,
  rs_multi_cdb_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]     r_busy, r_p1, r_p2, r_f7;
  logic [ROB_IDX_W-1:0] r_q1 [DEPTH];
  logic [ROB_IDX_W-1:0] r_q2 [DEPTH];
  logic [ROB_IDX_W-1:0] r_rob [DEPTH];
  logic [XLEN-1:0]      r_v1 [DEPTH];
  logic [XLEN-1:0]      r_v2 [DEPTH];
  logic [XLEN-1:0]      r_imm [DEPTH];
  logic [XLEN-1:0]      r_pc [DEPTH];
  logic [OP_W-1:0]      r_op [DEPTH];
  logic [F3_W-1:0]      r_f3 [DEPTH];

  logic                 r_alu_en, r_alu_f7;
  logic [OP_W-1:0]      r_alu_op;
  logic [F3_W-1:0]      r_alu_f3;
  logic [XLEN-1:0]      r_alu_imm, r_alu_pc, r_alu_v1, r_alu_v2;
  logic [ROB_IDX_W-1:0] r_alu_rob;

  logic [DEPTH-1:0]     w_wk1, w_wk2, w_rdy, w_gnt;
  logic [XLEN-1:0]      w_wv1 [DEPTH];
  logic [XLEN-1:0]      w_wv2 [DEPTH];
  logic [XLEN-1:0]      w_ov1 [DEPTH];
  logic [XLEN-1:0]      w_ov2 [DEPTH];
  logic                 w_iw1, w_iw2, w_free, w_gv, w_fire, w_nxt_full;
  logic [XLEN-1:0]      w_iv1, w_iv2;
  logic [IDX_W-1:0]     w_slot, w_gidx;
  logic [IDX_W:0]       w_cnt;

  // CDB tag match for stored and incoming operands; lowest port wins
  always_comb begin
    w_wk1 = '0;
    w_wk2 = '0;
    w_iw1 = 1'b0;
    w_iw2 = 1'b0;
    w_iv1 = '0;
    w_iv2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wv1[i] = '0;
      w_wv2[i] = '0;
    end
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (bus.cdb_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_q1[i] == bus.cdb_rob_pos[k*ROB_IDX_W +: ROB_IDX_W]) begin
            w_wk1[i] = 1'b1;
            w_wv1[i] = bus.cdb_val[k*XLEN +: XLEN];
          end
          if (r_q2[i] == bus.cdb_rob_pos[k*ROB_IDX_W +: ROB_IDX_W]) begin
            w_wk2[i] = 1'b1;
            w_wv2[i] = bus.cdb_val[k*XLEN +: XLEN];
          end
        end
        if (bus.issue_rs1_tag[ROB_IDX_W-1:0] ==
            bus.cdb_rob_pos[k*ROB_IDX_W +: ROB_IDX_W]) begin
          w_iw1 = 1'b1;
          w_iv1 = bus.cdb_val[k*XLEN +: XLEN];
        end
        if (bus.issue_rs2_tag[ROB_IDX_W-1:0] ==
            bus.cdb_rob_pos[k*ROB_IDX_W +: ROB_IDX_W]) begin
          w_iw2 = 1'b1;
          w_iv2 = bus.cdb_val[k*XLEN +: XLEN];
        end
      end
    end
  end

  // per-entry readiness and the operand value handed to the ALU
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_CDB_BYPASS_EN
      w_rdy[i] = r_busy[i] & (~r_p1[i] | w_wk1[i]) & (~r_p2[i] | w_wk2[i]);
      w_ov1[i] = r_p1[i] ? w_wv1[i] : r_v1[i];
      w_ov2[i] = r_p2[i] ? w_wv2[i] : r_v2[i];
`else
      w_rdy[i] = r_busy[i] & ~r_p1[i] & ~r_p2[i];
      w_ov1[i] = r_v1[i];
      w_ov2[i] = r_v2[i];
`endif
    end
  end

  // lowest free slot, occupancy and grant index
  always_comb begin
    w_slot = RS_NPOS[IDX_W-1:0];
    w_free = 1'b0;
    w_cnt  = '0;
    w_gidx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_slot = IDX_W'(i);
        w_free = 1'b1;
      end
      if (w_gnt[i]) w_gidx = IDX_W'(i);
      w_cnt = w_cnt + (IDX_W+1)'(r_busy[i]);
    end
  end

  assign w_fire = rdy & ~rollback & bus.issue & w_free;

  rs_age_pick #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .i_busy  (r_busy),
    .i_ready (w_rdy),
    .i_issue (w_fire),
    .i_slot  (w_slot),
    .o_grant (w_gnt),
    .o_valid (w_gv)
  );

  // occupancy at the end of this cycle reaches DEPTH
  always_comb begin
    if (rst || (rdy && rollback))
      w_nxt_full = 1'b0;
    else if (!rdy)
      w_nxt_full = (w_cnt == FULL);
    else
      w_nxt_full = (w_cnt - (IDX_W+1)'(w_gv)
                    + (IDX_W+1)'(bus.issue)) == FULL;
  end

  // entry state, wakeup, issue write and registered dispatch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_alu_en  <= 1'b0;
      r_alu_op  <= '0;
      r_alu_f3  <= '0;
      r_alu_f7  <= 1'b0;
      r_alu_imm <= '0;
      r_alu_pc  <= '0;
      r_alu_v1  <= '0;
      r_alu_v2  <= '0;
      r_alu_rob <= '0;
    end else if (rdy) begin
      if (rollback) begin
        r_busy   <= '0;
        r_alu_en <= 1'b0;
      end else begin
        r_alu_en <= w_gv;
        if (w_gv) begin
          r_alu_op       <= r_op[w_gidx];
          r_alu_f3       <= r_f3[w_gidx];
          r_alu_f7       <= r_f7[w_gidx];
          r_alu_imm      <= r_imm[w_gidx];
          r_alu_pc       <= r_pc[w_gidx];
          r_alu_v1       <= w_ov1[w_gidx];
          r_alu_v2       <= w_ov2[w_gidx];
          r_alu_rob      <= r_rob[w_gidx];
          r_busy[w_gidx] <= 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (r_busy[i] && r_p1[i] && w_wk1[i]) begin
            r_p1[i] <= 1'b0;
            r_v1[i] <= w_wv1[i];
          end
          if (r_busy[i] && r_p2[i] && w_wk2[i]) begin
            r_p2[i] <= 1'b0;
            r_v2[i] <= w_wv2[i];
          end
        end
        if (w_fire) begin
          r_busy[w_slot] <= 1'b1;
          r_op[w_slot]   <= bus.issue_opcode;
          r_f3[w_slot]   <= bus.issue_funct3;
          r_f7[w_slot]   <= bus.issue_funct7;
          r_imm[w_slot]  <= bus.issue_imm;
          r_pc[w_slot]   <= bus.issue_pc;
          r_rob[w_slot]  <= bus.issue_rob_pos;
          r_q1[w_slot]   <= bus.issue_rs1_tag[ROB_IDX_W-1:0];
          r_q2[w_slot]   <= bus.issue_rs2_tag[ROB_IDX_W-1:0];
          r_p1[w_slot]   <= bus.issue_rs1_tag[ROB_IDX_W] & ~w_iw1;
          r_p2[w_slot]   <= bus.issue_rs2_tag[ROB_IDX_W] & ~w_iw2;
          r_v1[w_slot]   <= (bus.issue_rs1_tag[ROB_IDX_W] && w_iw1)
                            ? w_iv1 : bus.issue_rs1_val;
          r_v2[w_slot]   <= (bus.issue_rs2_tag[ROB_IDX_W] && w_iw2)
                            ? w_iv2 : bus.issue_rs2_val;
        end
      end
    end
  end

  assign bus.rs_nxt_full = w_nxt_full;
  assign bus.alu_en      = r_alu_en;
  assign bus.alu_opcode  = r_alu_op;
  assign bus.alu_funct3  = r_alu_f3;
  assign bus.alu_funct7  = r_alu_f7;
  assign bus.alu_imm     = r_alu_imm;
  assign bus.alu_pc      = r_alu_pc;
  assign bus.alu_val1    = r_alu_v1;
  assign bus.alu_val2    = r_alu_v2;
  assign bus.alu_rob_pos = r_alu_rob;

  a_iss_full: assert property (@(posedge clk) disable iff (rst)
    (rdy && !rollback && bus.issue) |-> (w_cnt != FULL))
    else $error("rs_multi_cdb: issue into a full station");
endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
Parametrised reservation station for the ALU pipe of the out-of-order core. It accepts one instruction per cycle from issue, holds it until both source operands are valid, then dispatches one ready entry per cycle to the ALU, oldest first. Operands are woken by NUM_CDB result broadcast ports (ALU, LSB, and later units). It flushes on rollback and freezes when rdy is low.

Parameters:
DEPTH, 16, number of entries; power of two, 2..64
ROB_IDX_W, 4, ROB position width; a tag is {pending, rob_pos}, so tags are ROB_IDX_W+1 bits
XLEN, 32, operand and result width
NUM_CDB, 2, number of result broadcast ports
OP_W, 7, opcode width
F3_W, 3, funct3 width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = hold all state
rollback  in  1  mispredict flush
issue  in  1  write one entry this cycle
issue_opcode  in  OP_W  opcode
issue_funct3  in  F3_W  funct3
issue_funct7  in  1  funct7 bit 5
issue_imm  in  XLEN  immediate
issue_pc  in  XLEN  instruction PC
issue_rob_pos  in  ROB_IDX_W  destination ROB slot
issue_rs1_tag  in  ROB_IDX_W+1  MSB=1: waiting on rob_pos; MSB=0: issue_rs1_val is valid
issue_rs2_tag  in  ROB_IDX_W+1  same encoding, for rs2
issue_rs1_val  in  XLEN  rs1 value
issue_rs2_val  in  XLEN  rs2 value
rs_nxt_full  out  1  occupancy at end of this cycle equals DEPTH
alu_en  out  1  one-cycle dispatch pulse
alu_opcode/alu_funct3/alu_funct7/alu_imm/alu_pc/alu_val1/alu_val2/alu_rob_pos  out  matching widths  dispatched entry contents
cdb_valid  in  NUM_CDB  broadcast valid, one bit per port
cdb_rob_pos  in  NUM_CDB*ROB_IDX_W  flat; port k is bits [k*ROB_IDX_W +: ROB_IDX_W]
cdb_val  in  NUM_CDB*XLEN  flat result values

Behaviour:
- Priority: rst, then !rdy (full hold, outputs unchanged), then rollback, then normal operation.
- rst or rollback: all busy bits clear. On the next edge alu_en=0; other alu_* are zeroed on rst and held on rollback. rollback overrides a same-cycle issue and dispatch.
- Issue write slot: lowest-index non-busy entry, computed from the current busy bits. A slot freed by dispatch this cycle is reusable next cycle.
- Issue capture: if a source tag matches a valid CDB port this cycle, the entry stores the CDB value with pending=0. No wakeup is lost.
- Wakeup: every busy entry with a pending source equal to {1,cdb_rob_pos[k]} with cdb_valid[k] latches the value and clears pending. If several ports match, the lowest k wins.
- Ready: busy and both pending bits 0, using registered state.
- Select: the oldest ready entry, via an age matrix. On issue, the new row is set to "younger than all busy entries".
- Dispatch: registered alu_* outputs. alu_en is high for exactly one cycle per dispatch. The entry is freed in the same edge.
- Latency: issue with both operands ready gives alu_en two edges after the issue edge.
- rs_nxt_full = (popcount(busy) - dispatch_this_cycle + issue) == DEPTH. Issue while rs_nxt_full was high last cycle is a protocol error; simulation asserts it. A full RS still dispatches.
- Reset values: alu_en=0, all alu_* =0, rs_nxt_full=0.

Optional Feature:
RS_CDB_BYPASS_EN
- Defined: an entry whose last pending operand is woken by a CDB this cycle counts as ready this cycle. The selected operand muxes from cdb_val. Wakeup-to-dispatch is 1 edge.
- Undefined: the woken entry is ready next cycle. Wakeup-to-dispatch is 2 edges.

Decomposition:
- Shared package/define file: ROB_IDX_W, tag pending-bit position, OP_W, F3_W, and the RS_NPOS sentinel (all-ones index).
- One sub-module: rs_age_pick. It holds the DEPTH x DEPTH age matrix and takes busy, ready, issue and the write slot. It outputs a one-hot oldest-ready grant and a valid flag.

Test Plan:
- rst, then issue ADD with rob 3, tags 0, vals 5 and 7 -> alu_en two edges later, alu_val1=5, alu_val2=7, alu_rob_pos=3, and rs_nxt_full never asserts.
- Issue entries for rob 1,2,3, all waiting on rob 9, then cdb0 broadcasts rob 9 = 0x10 -> dispatch order 1,2,3 on consecutive cycles, each with val1=0x10.
- Issue with rs1_tag={1,4} in the same cycle as cdb1 broadcasts rob 4 = 0xAB -> entry dispatches with alu_val1=0xAB, so the wakeup is not lost.
- Issue DEPTH entries all pending -> rs_nxt_full rises on the cycle of the DEPTH-th issue. One wakeup then clears it in the dispatch cycle.
- Fill 5 entries, then assert rollback together with issue -> no alu_en afterwards, and the next issue lands in slot 0.
- rdy low for 3 cycles while a CDB broadcast is valid -> no state change and alu_en held. With RS_CDB_BYPASS_EN on versus off, wakeup-to-alu_en is 1 versus 2 edges.
